// File: rtl/alu_unit_if.sv
// alu_unit_if: bundles the ALU operand, control, result and flag signals.
//   n          : operand/result width
//   a, b       : operands (master -> slave)
//   ALUControl : 00 ADD, 01 SUB, 10 AND, 11 OR (master -> slave)
//   FlagWrite  : flag register write enable (master -> slave)
//   ALUResult  : combinational result (slave -> master)
//   ALUFlags   : combinational {N,Z,C,V} (slave -> master)
//   FlagsQ     : registered {N,Z,C,V} (slave -> master)
interface alu_unit_if #(
  parameter int n = 32
);
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic [1:0]   ALUControl;
  logic         FlagWrite;
  logic [n-1:0] ALUResult;
  logic [3:0]   ALUFlags;
  logic [3:0]   FlagsQ;

  modport master (
    output a, b, ALUControl, FlagWrite,
    input  ALUResult, ALUFlags, FlagsQ
  );

  modport slave (
    input  a, b, ALUControl, FlagWrite,
    output ALUResult, ALUFlags, FlagsQ
  );
endinterface

// File: rtl/alu_unit.sv
// alu_unit: n-bit integer ALU (ADD, SUB, AND, OR) with {N,Z,C,V} flags and a
// write-enabled flag register.
//   clk   : clock, used only by the flag register
//   reset : asynchronous active-high, clears the flag register
//   bus   : alu_unit_if slave port (a, b, ALUControl, FlagWrite in;
//           ALUResult, ALUFlags, FlagsQ out)
// Result and ALUFlags are purely combinational; FlagsQ is the only state.
module alu_unit #(
  parameter int n = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_unit_if.slave bus
);

  // One-hot operation decode. An unknown opcode leaves every select low, so
  // the AND-OR mux below yields a zero result with C = V = 0 (flags 0100).
  logic sel_add;
  logic sel_sub;
  logic sel_and;
  logic sel_or;

  always_comb begin
    sel_add = 1'b0;
    sel_sub = 1'b0;
    sel_and = 1'b0;
    sel_or  = 1'b0;
    case (bus.ALUControl)
      2'b00:   sel_add = 1'b1;
      2'b01:   sel_sub = 1'b1;
      2'b10:   sel_and = 1'b1;
      2'b11:   sel_or  = 1'b1;
      default: ;
    endcase
  end

  logic sel_arith;
  assign sel_arith = sel_add | sel_sub;

  // Shared adder: SUB inverts b and injects a carry-in of 1.
  logic [n-1:0] b_eff;
  logic [n:0]   sum_ext;

  assign b_eff   = sel_sub ? ~bus.b : bus.b;
  assign sum_ext = {1'b0, bus.a} + {1'b0, b_eff} + {{n{1'b0}}, sel_sub};

  // Per-bit 4:1 result mux, built as an AND-OR of the one-hot selects.
  logic [n-1:0] result;

  generate
    for (genvar gi = 0; gi < n; gi++) begin : g_bit_mux
      assign result[gi] = (sel_arith & sum_ext[gi])
                        | (sel_and   & (bus.a[gi] & bus.b[gi]))
                        | (sel_or    & (bus.a[gi] | bus.b[gi]));
    end
  endgenerate

  // Overflow: operands into the adder share a sign that the sum does not.
  // Comparing against b_eff covers both ADD (same signs) and SUB (signs differ).
  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;

  assign flag_n = result[n-1];
  assign flag_z = ~|result;
  assign flag_c = sel_arith & sum_ext[n];
  assign flag_v = sel_arith & (bus.a[n-1] == b_eff[n-1]) & (result[n-1] != bus.a[n-1]);

  assign bus.ALUResult = result;
  assign bus.ALUFlags  = {flag_n, flag_z, flag_c, flag_v};

  // Flag register: reset wins over FlagWrite and acts without a clock edge.
  logic [3:0] flags_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg <= 4'b0000;
    end else if (bus.FlagWrite) begin
      flags_reg <= {flag_n, flag_z, flag_c, flag_v};
    end
  end

  assign bus.FlagsQ = flags_reg;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed, table-driven bench for alu_unit at n = 4.
module tb_alu_unit;

  localparam int N = 4;

  logic clk;
  logic reset;

  alu_unit_if #(.n(N)) ifc ();

  alu_unit #(.n(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] res;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs [16];

  initial begin
    vecs[0]  = '{"add 5+3", 4'h5, 4'h3, 2'b00, 4'h8, 4'b1001};
    vecs[1]  = '{"add 0+0", 4'h0, 4'h0, 2'b00, 4'h0, 4'b0100};
    vecs[2]  = '{"add 8+8", 4'h8, 4'h8, 2'b00, 4'h0, 4'b0111};
    vecs[3]  = '{"add 7+7", 4'h7, 4'h7, 2'b00, 4'hE, 4'b1001};
    vecs[4]  = '{"sub 5-3", 4'h5, 4'h3, 2'b01, 4'h2, 4'b0010};
    vecs[5]  = '{"sub 3-5", 4'h3, 4'h5, 2'b01, 4'hE, 4'b1000};
    vecs[6]  = '{"sub 8-0", 4'h8, 4'h0, 2'b01, 4'h8, 4'b1010};
    vecs[7]  = '{"sub 0-0", 4'h0, 4'h0, 2'b01, 4'h0, 4'b0110};
    vecs[8]  = '{"sub 8-1", 4'h8, 4'h1, 2'b01, 4'h7, 4'b0011};
    vecs[9]  = '{"sub 7-8", 4'h7, 4'h8, 2'b01, 4'hF, 4'b1001};
    vecs[10] = '{"and C&A", 4'hC, 4'hA, 2'b10, 4'h8, 4'b1000};
    vecs[11] = '{"and 3&5", 4'h3, 4'h5, 2'b10, 4'h1, 4'b0000};
    vecs[12] = '{"and A&5", 4'hA, 4'h5, 2'b10, 4'h0, 4'b0100};
    vecs[13] = '{"or C|A",  4'hC, 4'hA, 2'b11, 4'hE, 4'b1000};
    vecs[14] = '{"or 3|5",  4'h3, 4'h5, 2'b11, 4'h7, 4'b0000};
    vecs[15] = '{"or 0|0",  4'h0, 4'h0, 2'b11, 4'h0, 4'b0100};

    reset          = 1'b1;
    ifc.a          = 4'h0;
    ifc.b          = 4'h0;
    ifc.ALUControl = 2'b00;
    ifc.FlagWrite  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset FlagsQ", {4'h0, ifc.FlagsQ}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Combinational vectors, FlagWrite held low
    for (int i = 0; i < 16; i++) begin
      ifc.a          = vecs[i].a;
      ifc.b          = vecs[i].b;
      ifc.ALUControl = vecs[i].op;
      #1;
      $display("vec %-8s a=%h b=%h op=%b -> res=%h flags=%b (exp %h %b)",
               vecs[i].name, ifc.a, ifc.b, ifc.ALUControl,
               ifc.ALUResult, ifc.ALUFlags, vecs[i].res, vecs[i].flags);
      check({vecs[i].name, " result"}, {4'h0, ifc.ALUResult}, {4'h0, vecs[i].res});
      check({vecs[i].name, " flags"},  {4'h0, ifc.ALUFlags},  {4'h0, vecs[i].flags});
    end
    check("FlagsQ idle while FlagWrite low", {4'h0, ifc.FlagsQ}, 8'h00);

    // Unknown opcode: only meaningful where the simulator keeps X
    ifc.a          = 4'hA;
    ifc.b          = 4'h5;
    ifc.ALUControl = 2'bxx;
    #1;
    if ($isunknown(ifc.ALUControl)) begin
      $display("opcode xx a=A b=5 -> res=%h flags=%b", ifc.ALUResult, ifc.ALUFlags);
      check("xx result", {4'h0, ifc.ALUResult}, 8'h00);
      check("xx flags",  {4'h0, ifc.ALUFlags},  8'h04);
    end else begin
      $display("opcode xx not representable in this simulator, skipped");
    end

    // Capture 8+8 with one FlagWrite edge
    @(negedge clk);
    ifc.a = 4'h8; ifc.b = 4'h8; ifc.ALUControl = 2'b00; ifc.FlagWrite = 1'b1;
    @(posedge clk);
    #1;
    ifc.FlagWrite = 1'b0;
    $display("capture 8+8 -> FlagsQ=%b", ifc.FlagsQ);
    check("capture 8+8", {4'h0, ifc.FlagsQ}, 8'h07);

    // Switch to 5-3 with FlagWrite low: register holds
    @(negedge clk);
    ifc.a = 4'h5; ifc.b = 4'h3; ifc.ALUControl = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    $display("hold with 5-3 -> FlagsQ=%b ALUFlags=%b", ifc.FlagsQ, ifc.ALUFlags);
    check("hold FlagsQ", {4'h0, ifc.FlagsQ}, 8'h07);
    check("hold ALUFlags live", {4'h0, ifc.ALUFlags}, 8'h02);

    // Opcode and FlagWrite change in the same cycle: settled value captured
    @(negedge clk);
    ifc.a = 4'h7; ifc.b = 4'h8; ifc.ALUControl = 2'b01; ifc.FlagWrite = 1'b1;
    @(posedge clk);
    #1;
    ifc.FlagWrite = 1'b0;
    $display("capture 7-8 -> FlagsQ=%b", ifc.FlagsQ);
    check("capture 7-8", {4'h0, ifc.FlagsQ}, 8'h09);

    // Mid-cycle reset pulse clears without a clock edge
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    $display("mid-cycle reset -> FlagsQ=%b", ifc.FlagsQ);
    check("async reset clear", {4'h0, ifc.FlagsQ}, 8'h00);

    // Reset priority over FlagWrite across an edge
    ifc.FlagWrite = 1'b1;
    @(posedge clk);
    #1;
    check("reset beats FlagWrite", {4'h0, ifc.FlagsQ}, 8'h00);

    // First capture after reset release
    @(negedge clk);
    reset = 1'b0;
    ifc.a = 4'h3; ifc.b = 4'h5; ifc.ALUControl = 2'b01;
    @(posedge clk);
    #1;
    ifc.FlagWrite = 1'b0;
    $display("capture 3-5 after reset -> FlagsQ=%b", ifc.FlagsQ);
    check("first capture after reset", {4'h0, ifc.FlagsQ}, 8'h08);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Parameterized n-bit integer ALU for the processor datapath. It performs ADD, SUB, AND and OR on two operands and produces a result plus ARM-style condition flags {N, Z, C, V}. The result and flags are combinational. A clocked flag register with write enable holds the last committed flags for the condition-check logic.

## Interface
- n, default 32: operand and result width in bits (minimum 2).
- clk  in  1: single clock; only the flag register uses it.
- reset  in  1: asynchronous, active-high; clears the flag register.
- a  in  n: operand A.
- b  in  n: operand B.
- ALUControl  in  2: operation select; 00 ADD, 01 SUB, 10 AND, 11 OR.
- FlagWrite  in  1: when high, the flag register captures ALUFlags on the rising edge of clk.
- ALUResult  out  n: combinational result.
- ALUFlags  out  4: combinational flags {N, Z, C, V}; N is bit 3, V is bit 0.
- FlagsQ  out  4: registered flags {N, Z, C, V}.

## Operation
- ADD (00): {C, ALUResult} = a + b, computed at n+1 bits. C is the carry out of bit n-1.
- SUB (01): {C, ALUResult} = a + ~b + 1, computed at n+1 bits.
  - C = 1 means no borrow (a >= b unsigned). C = 0 means borrow.
  - a - 0 and 0 - 0 give C = 1.
- AND (10): ALUResult = a & b. C = 0, V = 0.
- OR (11): ALUResult = a | b. C = 0, V = 0.
- Any ALUControl value containing X or Z (simulation only):
  - ALUResult = 0.
  - ALUFlags = 0100 (N = 0, Z = 1, C = 0, V = 0).
- N = ALUResult[n-1] for every operation.
- Z = 1 exactly when ALUResult is all zeros, for every operation.
- V for ADD: a[n-1] == b[n-1] and ALUResult[n-1] != a[n-1].
- V for SUB: a[n-1] != b[n-1] and ALUResult[n-1] != a[n-1].
- Arithmetic is modulo 2^n. Wrap-around is reported only through C and V; there is no saturation.
- One adder is shared by ADD and SUB: b is inverted and the carry-in is 1 for SUB. Each result bit is selected by a 4:1 mux.

## Timing
- ALUResult and ALUFlags are purely combinational from a, b and ALUControl. There are zero cycles of latency and no internal state.
- FlagsQ:
  - Reset value is 0000.
  - reset asserted at any time clears FlagsQ immediately, without waiting for clk.
  - reset has priority over FlagWrite.
- On a rising edge of clk with reset low and FlagWrite high, FlagsQ takes the ALUFlags value present just before the edge.
- With FlagWrite low, FlagsQ holds its value.
- An operand or opcode change in the same cycle as FlagWrite is captured as the settled combinational value at the edge.
- After reset deasserts, the first capture happens on the first rising edge with FlagWrite high.

## Test plan
All cases use n = 4. Flags are written as NZCV.
- ADD:
  - 5 + 3 -> result 8, flags 1001.
  - 0 + 0 -> result 0, flags 0100.
  - 8 + 8 -> result 0, flags 0111.
  - 7 + 7 -> result E, flags 1001.
- SUB:
  - 5 - 3 -> result 2, flags 0010.
  - 3 - 5 -> result E, flags 1000.
  - 8 - 0 -> result 8, flags 1010.
  - 0 - 0 -> result 0, flags 0110.
  - 8 - 1 -> result 7, flags 0011.
  - 7 - 8 -> result F, flags 1001.
- AND:
  - C & A -> result 8, flags 1000.
  - 3 & 5 -> result 1, flags 0000.
  - A & 5 -> result 0, flags 0100.
- OR:
  - C | A -> result E, flags 1000.
  - 3 | 5 -> result 7, flags 0000.
  - 0 | 0 -> result 0, flags 0100.
- Invalid opcode: ALUControl = XX with a = A, b = 5 -> result 0, flags 0100.
- Flag register:
  - Pulse reset -> FlagsQ = 0000 immediately, without a clk edge.
  - Apply 8 + 8 with FlagWrite = 1 for one edge -> FlagsQ = 0111.
  - Switch to 5 - 3 with FlagWrite = 0 -> FlagsQ stays 0111.
  - Assert reset mid-cycle -> FlagsQ = 0000 before the next edge.
